uart_rx_core: RTL

Clocked, synthesisable UART receiver that deserialises an asynchronous `rx_i` line into characters and buffers them in a first-word-fall-through FIFO. Frame format is runtime-configurable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. It sits between the pad-side UART line and a uDMA RX channel or a testbench consumer, with valid/ready on the output side. Parity, framing and overflow errors are reported through sticky flags.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx_core.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// minimum bit divider and the newline character used by line tracking.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } rx_state_e;

   localparam int unsigned MIN_DIV = 4;
   localparam logic [7:0]  NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count. A pop in the same cycle
// as a push into a full FIFO frees the slot so the push is accepted.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CW'(DEPTH));
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      data_o  = empty_o ? '0 : mem_q[rptr_q];
      count_o = count_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: synchroniser, frame FSM, sticky errors and RX FIFO.
// Optional line tracking (line_done_o / line_len_o) is built with UART_RX_LINE_EN.
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LINE_LEN_W  = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_en_i,
   input  logic [DIV_W-1:0]              cfg_div_i,
   input  logic [1:0]                    cfg_bits_i,
   input  logic                          cfg_parity_en_i,
   input  logic                          cfg_parity_odd_i,
   input  logic                          cfg_stop2_i,
   input  logic                          rx_i,
   output logic [7:0]                    data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          err_parity_o,
   output logic                          err_frame_o,
   output logic                          err_overflow_o,
   input  logic                          err_clr_i,
   output logic                          line_done_o,
   output logic [LINE_LEN_W-1:0]         line_len_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_prev_q;
   logic                   rx_s, fall;

   rx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_err_q, par_err_d;
   logic              frame_bad_q, frame_bad_d;
   logic              stop2nd_q, stop2nd_d;
   logic              err_par_q, err_par_d;
   logic              err_frm_q, err_frm_d;
   logic              err_ovf_q, err_ovf_d;

   logic [DIV_W-1:0]  div_eff, half;
   logic [2:0]        last_bit;
   logic              tick, push, push_ok, pop_ok, set_par, set_frm;
   logic              fifo_full, fifo_empty;

   assign rx_s = sync_q[SYNC_STAGES-1];
   assign fall = rx_prev_q & ~rx_s;

   always_comb begin
      div_eff     = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
      half        = div_eff >> 1;
      last_bit    = 3'(cfg_bits_i) + 3'd4;
      tick        = (cnt_q == '0);
      state_d     = state_q;
      cnt_d       = tick ? cnt_q : cnt_q - 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_err_d   = par_err_q;
      frame_bad_d = frame_bad_q;
      stop2nd_d   = stop2nd_q;
      push        = 1'b0;
      set_par     = 1'b0;
      set_frm     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fall) begin
               cnt_d   = half - DIV_W'(1);
               state_d = StStart;
            end
         end
         StStart: begin
            if (tick) begin
               if (rx_s) begin
                  state_d = StIdle;
               end else begin
                  cnt_d       = div_eff - DIV_W'(1);
                  bit_d       = '0;
                  shift_d     = '0;
                  par_err_d   = 1'b0;
                  frame_bad_d = 1'b0;
                  stop2nd_d   = 1'b0;
                  state_d     = StData;
               end
            end
         end
         StData: begin
            if (tick) begin
               shift_d[bit_q] = rx_s;
               bit_d          = bit_q + 1'b1;
               cnt_d          = div_eff - DIV_W'(1);
               if (bit_q == last_bit) begin
                  state_d = cfg_parity_en_i ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (tick) begin
               par_err_d = rx_s ^ (^shift_q) ^ cfg_parity_odd_i;
               cnt_d     = div_eff - DIV_W'(1);
               state_d   = StStop;
            end
         end
         StStop: begin
            if (tick) begin
               set_frm = ~rx_s;
               if (cfg_stop2_i && !stop2nd_q) begin
                  stop2nd_d   = 1'b1;
                  frame_bad_d = frame_bad_q | ~rx_s;
                  cnt_d       = div_eff - DIV_W'(1);
               end else begin
                  // Good frames only: a bad stop bit discards the character.
                  push    = ~frame_bad_q & rx_s;
                  set_par = push & par_err_q;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (!cfg_en_i) begin
         state_d = StIdle;
         push    = 1'b0;
         set_par = 1'b0;
         set_frm = 1'b0;
      end
      pop_ok    = ready_i & ~fifo_empty;
      push_ok   = push & (~fifo_full | pop_ok);
      err_par_d = set_par | (err_par_q & ~err_clr_i);
      err_frm_d = set_frm | (err_frm_q & ~err_clr_i);
      err_ovf_d = (push & ~push_ok) | (err_ovf_q & ~err_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q      <= '1;
         rx_prev_q   <= 1'b1;
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         par_err_q   <= 1'b0;
         frame_bad_q <= 1'b0;
         stop2nd_q   <= 1'b0;
         err_par_q   <= 1'b0;
         err_frm_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rx_prev_q   <= rx_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         par_err_q   <= par_err_d;
         frame_bad_q <= frame_bad_d;
         stop2nd_q   <= stop2nd_d;
         err_par_q   <= err_par_d;
         err_frm_q   <= err_frm_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign err_parity_o   = err_par_q;
   assign err_frame_o    = err_frm_q;
   assign err_overflow_o = err_ovf_q;
   assign valid_o        = ~fifo_empty;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (shift_q),
      .pop_i   (ready_i),
      .data_o  (data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_o)
   );

`ifdef UART_RX_LINE_EN
   logic [LINE_LEN_W-1:0] line_cnt_q, line_cnt_d;
   logic [LINE_LEN_W-1:0] line_len_q, line_len_d;
   logic                  line_done_q, line_done_d;

   always_comb begin
      line_cnt_d  = line_cnt_q;
      line_len_d  = line_len_q;
      line_done_d = 1'b0;
      if (push_ok) begin
         if (shift_q == NEWLINE) begin
            line_len_d  = line_cnt_q;
            line_cnt_d  = '0;
            line_done_d = 1'b1;
         end else if (line_cnt_q != '1) begin
            line_cnt_d = line_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         line_cnt_q  <= '0;
         line_len_q  <= '0;
         line_done_q <= 1'b0;
      end else begin
         line_cnt_q  <= line_cnt_d;
         line_len_q  <= line_len_d;
         line_done_q <= line_done_d;
      end
   end

   assign line_done_o = line_done_q;
   assign line_len_o  = line_len_q;
`else
   assign line_done_o = 1'b0;
   assign line_len_o  = '0;
`endif

endmodule
